bsg_mem_1rw_sync_req_ctrl: RTL and testbench

Initiator-side controller that drives a bsg_mem_1rw_sync port from a ready/valid request stream. Read responses come back on a valid/yumi stream.
- Absorbs the RAM's fixed one-cycle read latency and buffers responses against downstream backpressure.
- Optionally zero-fills the RAM after reset.
- Sits between a client (cache or table logic) and a single-port synchronous RAM instance.

---
 rtl/bsg_mem_1rw_sync_req_ctrl_pkg.sv | 9 +
 rtl/bsg_mem_1rw_sync_req_ctrl_if.sv | 16 +
 rtl/bsg_mem_1rw_sync_req_ctrl_fifo.sv | 47 ++++
 rtl/bsg_mem_1rw_sync_req_ctrl.sv | 69 ++++++
 tb/tb_bsg_mem_1rw_sync_req_ctrl.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/bsg_mem_1rw_sync_req_ctrl_pkg.sv
// bsg_mem_1rw_sync_req_ctrl_pkg: state encoding and width helper for the 1rw sync RAM request controller
package bsg_mem_1rw_sync_req_ctrl_pkg;
   typedef logic [0:0] state_t;
   localparam state_t eInit  = 1'b0;
   localparam state_t eReady = 1'b1;
   function automatic int safe_clog2(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/bsg_mem_1rw_sync_req_ctrl_if.sv
// bsg_mem_1rw_sync_req_ctrl_if: client-facing ready/valid request and valid/yumi response bundle
interface bsg_mem_1rw_sync_req_ctrl_if #(
   parameter int width_p      = 8,
   parameter int addr_width_p = 4
);
   logic                    v_i;
   logic                    w_i;
   logic [addr_width_p-1:0] addr_i;
   logic [width_p-1:0]      data_i;
   logic                    ready_o;
   logic                    v_o;
   logic [width_p-1:0]      data_o;
   logic                    yumi_i;
   modport master (output v_i, w_i, addr_i, data_i, yumi_i, input ready_o, v_o, data_o);
   modport slave  (input v_i, w_i, addr_i, data_i, yumi_i, output ready_o, v_o, data_o);
endinterface

// File: rtl/bsg_mem_1rw_sync_req_ctrl_fifo.sv
// bsg_fifo_1r1w_small: small circular FIFO, ready/valid in, valid/yumi out, exposes occupancy
module bsg_fifo_1r1w_small #(
   parameter int  width_p  = 8,
   parameter int  els_p    = 3,
   localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1,
   localparam int cnt_w_lp = $clog2(els_p + 1)
) (
   input  logic                clk_i,
   input  logic                reset_i,
   input  logic                v_i,
   output logic                ready_o,
   input  logic [width_p-1:0]  data_i,
   output logic                v_o,
   output logic [width_p-1:0]  data_o,
   input  logic                yumi_i,
   output logic [cnt_w_lp-1:0] count_o
);
   logic [width_p-1:0]  mem_r [els_p];
   logic [ptr_w_lp-1:0] rptr_r, wptr_r;
   logic [cnt_w_lp-1:0] cnt_r;
   logic                push, pop;
   function automatic logic [ptr_w_lp-1:0] nxt(input logic [ptr_w_lp-1:0] p);
      return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + ptr_w_lp'(1);
   endfunction
   assign ready_o = cnt_r != cnt_w_lp'(els_p);
   assign v_o     = cnt_r != '0;
   assign push    = v_i & ready_o;
   assign pop     = yumi_i & v_o;
   assign data_o  = mem_r[rptr_r];
   assign count_o = cnt_r;
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         rptr_r <= '0;
         wptr_r <= '0;
         cnt_r  <= '0;
      end else begin
         if (push) begin
            mem_r[wptr_r] <= data_i;
            wptr_r        <= nxt(wptr_r);
         end
         if (pop) rptr_r <= nxt(rptr_r);
         cnt_r <= cnt_r + cnt_w_lp'(push) - cnt_w_lp'(pop);
         assert (!(v_i && !ready_o)) else $error("push into full response buffer");
         assert (!(yumi_i && !v_o)) else $error("pop from empty response buffer");
      end
   end
endmodule

// File: rtl/bsg_mem_1rw_sync_req_ctrl.sv
// bsg_mem_1rw_sync_req_ctrl: drives a 1rw sync RAM from a request stream, buffers read responses
// against backpressure, and optionally zero-fills the RAM after reset.
module bsg_mem_1rw_sync_req_ctrl
   import bsg_mem_1rw_sync_req_ctrl_pkg::*;
#(
   parameter int  width_p       = 8,
   parameter int  els_p         = 16,
   parameter int  resp_els_p    = 3,
   parameter bit  init_p        = 1'b1,
   localparam int addr_width_lp = safe_clog2(els_p),
   localparam int cnt_w_lp      = $clog2(resp_els_p + 1)
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   bsg_mem_1rw_sync_req_ctrl_if.slave req,
   output logic                     mem_v_o,
   output logic                     mem_w_o,
   output logic [addr_width_lp-1:0] mem_addr_o,
   output logic [width_p-1:0]       mem_data_o,
   input  logic [width_p-1:0]       mem_data_i,
   output logic                     init_done_o
);
   state_t                   state_r;
   logic [addr_width_lp-1:0] cnt_r;
   logic                     inflight_r;
   logic                     in_init, in_ready, credit_ok, ready, accept, last;
   logic                     fifo_ready, fifo_v;
   logic [cnt_w_lp-1:0]      count;
   // Outputs are gated by reset so the reset cycle is quiet regardless of the stale state.
   assign in_init     = ~reset_i & (state_r == eInit);
   assign in_ready    = ~reset_i & (state_r == eReady);
   assign last        = cnt_r == addr_width_lp'(els_p - 1);
   assign credit_ok   = (int'(count) + int'(inflight_r)) < resp_els_p;
   assign ready       = in_ready & (req.w_i | credit_ok);
   assign accept      = req.v_i & ready;
   assign req.ready_o = ready;
   assign req.v_o     = fifo_v & ~reset_i;
   assign init_done_o = in_ready;
   assign mem_v_o     = in_init | accept;
   assign mem_w_o     = in_init | req.w_i;
   assign mem_addr_o  = in_init ? cnt_r : req.addr_i;
   assign mem_data_o  = in_init ? '0 : req.data_i;
   bsg_fifo_1r1w_small #(.width_p(width_p), .els_p(resp_els_p)) resp_fifo (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .v_i     (inflight_r),
      .ready_o (fifo_ready),
      .data_i  (mem_data_i),
      .v_o     (fifo_v),
      .data_o  (req.data_o),
      .yumi_i  (req.yumi_i),
      .count_o (count)
   );
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_r    <= init_p ? eInit : eReady;
         cnt_r      <= '0;
         inflight_r <= 1'b0;
      end else begin
         inflight_r <= accept & ~req.w_i;
         if (in_init) begin
            cnt_r <= last ? cnt_r : cnt_r + addr_width_lp'(1);
            if (last) state_r <= eReady;
         end
         assert (!(req.yumi_i && !req.v_o)) else $error("yumi_i asserted with no response valid");
         assert (!(inflight_r && !fifo_ready)) else $error("read response arrived with buffer full");
      end
   end
endmodule

// File: tb/tb_bsg_mem_1rw_sync_req_ctrl.sv
// tb_bsg_mem_1rw_sync_req_ctrl: directed bench with a behavioural 1rw sync RAM behind the controller
module tb_bsg_mem_1rw_sync_req_ctrl;
   logic       clk = 1'b0;
   logic       reset_i;
   logic       mem_v, mem_w, init_done;
   logic [3:0] mem_addr;
   logic [7:0] mem_wdata, ram_q;
   logic [7:0] ram [16];
   int         n_chk = 0;
   int         n_fail = 0;
   bsg_mem_1rw_sync_req_ctrl_if #(.width_p(8), .addr_width_p(4)) ifc ();
   bsg_mem_1rw_sync_req_ctrl #(.width_p(8), .els_p(16), .resp_els_p(3), .init_p(1'b1)) dut (
      .clk_i       (clk),
      .reset_i     (reset_i),
      .req         (ifc),
      .mem_v_o     (mem_v),
      .mem_w_o     (mem_w),
      .mem_addr_o  (mem_addr),
      .mem_data_o  (mem_wdata),
      .mem_data_i  (ram_q),
      .init_done_o (init_done)
   );
   always #5 clk = ~clk;
   always_ff @(posedge clk)
      if (mem_v) begin
         if (mem_w) ram[mem_addr] <= mem_wdata;
         else ram_q <= ram[mem_addr];
      end
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic wr(input logic [3:0] a, input logic [7:0] d);
      ifc.v_i = 1'b1; ifc.w_i = 1'b1; ifc.addr_i = a; ifc.data_i = d;
      #1;
      chk("wr_ready", 32'(ifc.ready_o), 1);
      tick;
      ifc.v_i = 1'b0; ifc.w_i = 1'b0;
   endtask
   task automatic rd(input logic [3:0] a);
      ifc.v_i = 1'b1; ifc.w_i = 1'b0; ifc.addr_i = a;
      #1;
      chk("rd_ready", 32'(ifc.ready_o), 1);
      tick;
      ifc.v_i = 1'b0;
   endtask
   task automatic resp(input logic [7:0] d);
      ifc.yumi_i = 1'b1;
      #1;
      chk("resp_v", 32'(ifc.v_o), 1);
      chk("resp_data", 32'(ifc.data_o), 32'(d));
      tick;
      ifc.yumi_i = 1'b0;
   endtask
   task automatic quiet(input string tag);
      #1;
      chk(tag, 32'(ifc.v_o), 0);
      tick;
   endtask
   task automatic init_seq(input string tag);
      for (int i = 0; i < 16; i++) begin
         #1;
         chk({tag, "_mem_v"}, 32'(mem_v), 1);
         chk({tag, "_mem_w"}, 32'(mem_w), 1);
         chk({tag, "_addr"}, 32'(mem_addr), 32'(i));
         chk({tag, "_data"}, 32'(mem_wdata), 0);
         chk({tag, "_ready"}, 32'(ifc.ready_o), 0);
         chk({tag, "_v_o"}, 32'(ifc.v_o), 0);
         tick;
      end
      #1;
      chk({tag, "_done"}, 32'(init_done), 1);
      chk({tag, "_ready_after"}, 32'(ifc.ready_o), 1);
   endtask
   initial begin
      reset_i = 1'b1;
      ifc.v_i = 1'b0; ifc.w_i = 1'b0; ifc.addr_i = '0; ifc.data_i = '0; ifc.yumi_i = 1'b0;
      tick;
      chk("rst_ready", 32'(ifc.ready_o), 0);
      chk("rst_v_o", 32'(ifc.v_o), 0);
      chk("rst_mem_v", 32'(mem_v), 0);
      chk("rst_done", 32'(init_done), 0);
      tick;
      reset_i = 1'b0;
      init_seq("init");
      tick;
      rd(4'd5);
      quiet("t1_latency");
      resp(8'h00);
      wr(4'd3, 8'hA5);
      rd(4'd3);
      quiet("t2_latency");
      resp(8'hA5);
      for (int a = 0; a < 8; a++) wr(4'(a), 8'(16 + a));
      for (int i = 0; i < 10; i++) begin
         ifc.v_i = (i < 8); ifc.w_i = 1'b0; ifc.addr_i = 4'(i); ifc.yumi_i = (i >= 2);
         #1;
         if (i < 8) chk("t3_ready", 32'(ifc.ready_o), 1);
         if (i >= 2) begin
            chk("t3_v_o", 32'(ifc.v_o), 1);
            chk("t3_data", 32'(ifc.data_o), 32'(16 + i - 2));
         end
         tick;
      end
      ifc.v_i = 1'b0; ifc.yumi_i = 1'b0;
      quiet("t3_drained");
      for (int i = 0; i < 5; i++) begin
         ifc.v_i = 1'b1; ifc.w_i = 1'b0; ifc.addr_i = 4'(i);
         #1;
         chk("t4_read_credit", 32'(ifc.ready_o), (i < 3) ? 1 : 0);
         tick;
      end
      ifc.w_i = 1'b1; ifc.addr_i = 4'd9; ifc.data_i = 8'h99;
      #1;
      chk("t4_write_stalled", 32'(ifc.ready_o), 1);
      chk("t4_head_v", 32'(ifc.v_o), 1);
      chk("t4_head_data", 32'(ifc.data_o), 32'h10);
      tick;
      ifc.w_i = 1'b0;
      #1;
      chk("t4_read_blocked", 32'(ifc.ready_o), 0);
      tick;
      ifc.v_i = 1'b0;
      resp(8'h10);
      resp(8'h11);
      resp(8'h12);
      rd(4'd9);
      quiet("t4_latency");
      resp(8'h99);
      wr(4'd2, 8'h11);
      rd(4'd2);
      wr(4'd2, 8'h22);
      resp(8'h11);
      rd(4'd2);
      quiet("t5_latency");
      resp(8'h22);
      rd(4'd0);
      rd(4'd1);
      rd(4'd2);
      #1;
      chk("t6_pre_v_o", 32'(ifc.v_o), 1);
      reset_i = 1'b1;
      #1;
      chk("t6_rst_v_o", 32'(ifc.v_o), 0);
      chk("t6_rst_ready", 32'(ifc.ready_o), 0);
      chk("t6_rst_mem_v", 32'(mem_v), 0);
      chk("t6_rst_done", 32'(init_done), 0);
      tick;
      reset_i = 1'b0;
      init_seq("t6_reinit");
      tick;
      quiet("t6_no_stale");
      rd(4'd2);
      quiet("t6_latency");
      resp(8'h00);
      quiet("t6_end");
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
